// File: rtl/alu_flags_unit.sv
// Purpose : one ALU op per request; writes the {N,Z,V,C} nibble to the flags register via flags_cs.
// Latency : single-cycle ops done 2 cycles after the accept edge; MUL done WIDTH+2 cycles after it.
// Backpr. : none queued; start is ignored while busy=1 (caller must wait for busy=0).
//
// Ports   : clk/reset_n (async active-low); start/op/a/b request, sampled on acceptance;
//           busy, done pulse, result (held to next done), flags_cs strobe, flags_out (held to next flags_cs).
// Macro   : ALU_MUL_EN builds the iterative shift-add MUL (op 11); without it op 11 is an invalid op.
module alu_flags_unit #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             flags_cs,
   output logic [3:0]       flags_out
);

   localparam int MSB = WIDTH - 1;

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_ADC = 4'd1;
   localparam logic [3:0] OP_SUB = 4'd2;
   localparam logic [3:0] OP_SBC = 4'd3;
   localparam logic [3:0] OP_CMP = 4'd4;
   localparam logic [3:0] OP_AND = 4'd5;
   localparam logic [3:0] OP_OR  = 4'd6;
   localparam logic [3:0] OP_XOR = 4'd7;
   localparam logic [3:0] OP_LSL = 4'd8;
   localparam logic [3:0] OP_LSR = 4'd9;
   localparam logic [3:0] OP_ASR = 4'd10;
`ifdef ALU_MUL_EN
   localparam logic [3:0] OP_MUL = 4'd11;
`endif

`ifdef ALU_MUL_EN
   typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, DONE = 2'd2, MUL = 2'd3} state_t;
`else
   typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, DONE = 2'd2} state_t;
`endif

   state_t state, state_n;
   logic   busy_n, done_n, cs_n;

   logic [3:0]       op_q;
   logic [WIDTH-1:0] a_q, b_q;
   logic             carry_q;

   // Staging registers: the computed value is parked here so result/flags_out
   // only change together with the done pulse.
   logic [WIDTH-1:0] calc_res;
   logic [3:0]       calc_flg;
   logic             calc_wr;

   logic             cin;
   logic [WIDTH:0]   add_s, sub_d;
   logic [WIDTH-1:0] alu_val;
   logic             alu_c, alu_v, alu_wr;

`ifdef ALU_MUL_EN
   localparam int CW = $clog2(WIDTH + 1);
   logic [2*WIDTH-1:0] prod;
   logic [CW-1:0]      cnt;
   logic               mul_last;
   logic [WIDTH:0]     mul_sum;

   // prod starts as {0, b}; each step adds a into the upper half when the
   // current multiplier bit is set, then shifts the whole product right.
   // After WIDTH steps one more MUL cycle forms the flags from the product.
   assign mul_last = (cnt == CW'(WIDTH));
   assign mul_sum  = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
`endif

   // ---------------- FSM ----------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         busy     <= 1'b0;
         done     <= 1'b0;
         flags_cs <= 1'b0;
      end else begin
         state    <= state_n;
         busy     <= busy_n;
         done     <= done_n;
         flags_cs <= cs_n;
      end
   end

   always_comb begin
      state_n = state;
      done_n  = 1'b0;
      cs_n    = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_n = EXEC;
`ifdef ALU_MUL_EN
               if (op == OP_MUL) state_n = MUL;
`endif
            end
         end
         EXEC: state_n = DONE;
`ifdef ALU_MUL_EN
         MUL:  if (mul_last) state_n = DONE;
`endif
         DONE: begin
            state_n = IDLE;
            done_n  = 1'b1;
            cs_n    = calc_wr;
         end
         default: state_n = IDLE;
      endcase
      busy_n = (state_n != IDLE);
   end

   // ---------------- single-cycle ALU ----------------
   always_comb begin
      cin     = ((op_q == OP_ADC) || (op_q == OP_SBC)) ? carry_q : 1'b0;
      add_s   = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, cin};
      // Top bit of the difference is the borrow: set when a < b + cin unsigned.
      sub_d   = {1'b0, a_q} - {1'b0, b_q} - {{WIDTH{1'b0}}, cin};
      alu_val = '0;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      alu_wr  = 1'b1;
      case (op_q)
         OP_ADD, OP_ADC: begin
            alu_val = add_s[WIDTH-1:0];
            alu_c   = add_s[WIDTH];
            alu_v   = (a_q[MSB] == b_q[MSB]) && (alu_val[MSB] != a_q[MSB]);
         end
         OP_SUB, OP_SBC, OP_CMP: begin
            alu_val = sub_d[WIDTH-1:0];
            alu_c   = sub_d[WIDTH];
            alu_v   = (a_q[MSB] != b_q[MSB]) && (alu_val[MSB] != a_q[MSB]);
         end
         OP_AND: alu_val = a_q & b_q;
         OP_OR:  alu_val = a_q | b_q;
         OP_XOR: alu_val = a_q ^ b_q;
         OP_LSL: begin
            alu_val = {a_q[WIDTH-2:0], 1'b0};
            alu_c   = a_q[MSB];
            alu_v   = alu_val[MSB] ^ alu_c;
         end
         OP_LSR: begin
            alu_val = {1'b0, a_q[WIDTH-1:1]};
            alu_c   = a_q[0];
            alu_v   = alu_val[MSB] ^ alu_c;
         end
         OP_ASR: begin
            alu_val = {a_q[MSB], a_q[WIDTH-1:1]};
            alu_c   = a_q[0];
            alu_v   = alu_val[MSB] ^ alu_c;
         end
         default: alu_wr = 1'b0;   // invalid op: result 0, no flag write
      endcase
   end

   // ---------------- datapath ----------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         op_q      <= '0;
         a_q       <= '0;
         b_q       <= '0;
         carry_q   <= 1'b0;
         calc_res  <= '0;
         calc_flg  <= '0;
         calc_wr   <= 1'b0;
         result    <= '0;
         flags_out <= '0;
`ifdef ALU_MUL_EN
         prod      <= '0;
         cnt       <= '0;
`endif
      end else begin
         if (state == IDLE && start) begin
            op_q <= op;
            a_q  <= a;
            b_q  <= b;
`ifdef ALU_MUL_EN
            prod <= {{WIDTH{1'b0}}, b};
            cnt  <= '0;
`endif
         end
         if (state == EXEC) begin
            // CMP only updates flags; its difference is discarded.
            calc_res <= !alu_wr ? '0 : ((op_q == OP_CMP) ? result : alu_val);
            calc_flg <= {alu_val[MSB], (alu_val == '0), alu_v, alu_c};
            calc_wr  <= alu_wr;
         end
`ifdef ALU_MUL_EN
         if (state == MUL) begin
            if (mul_last) begin
               calc_res <= prod[WIDTH-1:0];
               calc_flg <= {prod[MSB], (prod[WIDTH-1:0] == '0), 1'b0, |prod[2*WIDTH-1:WIDTH]};
               calc_wr  <= 1'b1;
            end else begin
               prod <= {mul_sum, prod[WIDTH-1:1]};
               cnt  <= cnt + CW'(1);
            end
         end
`endif
         if (state == DONE) begin
            result <= calc_res;
            if (calc_wr) begin
               flags_out <= calc_flg;
               carry_q   <= calc_flg[0];
            end
         end
      end
   end

endmodule

// File: tb/tb_alu_flags_unit.sv
// Bench for alu_flags_unit: directed ops, expected responses queued at issue,
// a negedge monitor pops and compares each done (result, flags, strobe, cycle).
module tb_alu_flags_unit;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       start = 1'b0;
   logic [3:0] op = '0;
   logic [7:0] a = '0;
   logic [7:0] b = '0;
   logic       busy, done, flags_cs;
   logic [7:0] result;
   logic [3:0] flags_out;

   alu_flags_unit #(.WIDTH(8)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .op(op), .a(a), .b(b),
      .busy(busy), .done(done), .result(result), .flags_cs(flags_cs), .flags_out(flags_out)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct packed {
      logic [7:0]  res;
      logic [3:0]  flg;
      logic        cs;
      logic [31:0] due;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;
   int   pops = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Monitor: every done must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (reset_n) begin
         if (done) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_done actual=1 required=0 (t=%0t)", $time);
            end else begin
               mon_e = sb.pop_front();
               chk("result", {24'd0, result}, {24'd0, mon_e.res});
               chk("flags_out", {28'd0, flags_out}, {28'd0, mon_e.flg});
               chk("flags_cs", {31'd0, flags_cs}, {31'd0, mon_e.cs});
               chk("done_cycle", cyc, mon_e.due);
               chk("busy_at_done", {31'd0, busy}, 32'd0);
               pops++;
            end
         end else if (flags_cs) begin
            checks++;
            errors++;
            $display("FAIL stray_flags_cs actual=1 required=0 (t=%0t)", $time);
         end
      end
   end

   task automatic run_op(input logic [3:0] o, input logic [7:0] va, input logic [7:0] vb,
                         input logic [7:0] eres, input logic [3:0] eflg, input logic ecs,
                         input int lat, input bit poke);
      exp_t x;
      int   target;
      int   n;
      @(negedge clk);
      op = o; a = va; b = vb; start = 1'b1;
      x.res = eres; x.flg = eflg; x.cs = ecs; x.due = cyc + 1 + lat;
      sb.push_back(x);
      target = pops + 1;
      @(posedge clk);
      #1 start = 1'b0;
      chk("busy_after_accept", {31'd0, busy}, 32'd1);
      if (poke) begin
         // A second request mid-operation must be dropped.
         repeat (3) @(negedge clk);
         op = 4'd0; a = 8'h01; b = 8'h01; start = 1'b1;
         @(negedge clk);
         start = 1'b0;
      end
      n = 0;
      while (pops < target && n < 40) begin
         @(posedge clk);
         n++;
      end
      if (pops < target) begin
         checks++;
         errors++;
         $display("FAIL done_timeout actual=none required=op%0d", o);
         void'(sb.pop_front());
      end
   endtask

`ifdef ALU_MUL_EN
   localparam logic [3:0] ABORT_OP = 4'd11;
   localparam int         ABORT_WAIT = 3;
`else
   localparam logic [3:0] ABORT_OP = 4'd1;
   localparam int         ABORT_WAIT = 0;
`endif

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_flags_cs", {31'd0, flags_cs}, 32'd0);
      chk("rst_result", {24'd0, result}, 32'd0);
      chk("rst_flags_out", {28'd0, flags_out}, 32'd0);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);

      //      op     a      b      result flags    cs   lat
      run_op(4'd0,  8'h7F, 8'h01, 8'h80, 4'b1010, 1'b1, 2, 0);  // ADD signed overflow
      run_op(4'd2,  8'h10, 8'h20, 8'hF0, 4'b1001, 1'b1, 2, 0);  // SUB borrow
      run_op(4'd3,  8'h05, 8'h05, 8'hFF, 4'b1001, 1'b1, 2, 0);  // SBC uses borrow
      run_op(4'd0,  8'h7F, 8'h01, 8'h80, 4'b1010, 1'b1, 2, 0);
      run_op(4'd4,  8'h33, 8'h33, 8'h80, 4'b0100, 1'b1, 2, 0);  // CMP keeps result
      run_op(4'd5,  8'hF0, 8'h3C, 8'h30, 4'b0000, 1'b1, 2, 0);  // AND
      run_op(4'd6,  8'h00, 8'h00, 8'h00, 4'b0100, 1'b1, 2, 0);  // OR zero
      run_op(4'd7,  8'hAA, 8'hFF, 8'h55, 4'b0000, 1'b1, 2, 0);  // XOR
      run_op(4'd8,  8'h81, 8'h00, 8'h02, 4'b0011, 1'b1, 2, 0);  // LSL C=1 V=1
      run_op(4'd1,  8'hFF, 8'h00, 8'h00, 4'b0101, 1'b1, 2, 0);  // ADC with carry in
      run_op(4'd9,  8'h01, 8'h00, 8'h00, 4'b0111, 1'b1, 2, 0);  // LSR
      run_op(4'd10, 8'h80, 8'h00, 8'hC0, 4'b1010, 1'b1, 2, 0);  // ASR
      run_op(4'hE,  8'h12, 8'h34, 8'h00, 4'b1010, 1'b0, 2, 0);  // invalid op
`ifdef ALU_MUL_EN
      run_op(4'd11, 8'hFF, 8'hFF, 8'h01, 4'b0001, 1'b1, 10, 1); // MUL max, start ignored
      run_op(4'd11, 8'h5B, 8'h00, 8'h00, 4'b0100, 1'b1, 10, 0); // MUL by zero
      run_op(4'd11, 8'h0F, 8'h0E, 8'hD2, 4'b1000, 1'b1, 10, 0);
`else
      run_op(4'd11, 8'hFF, 8'hFF, 8'h00, 4'b1010, 1'b0, 2, 0);  // MUL not built
`endif
      run_op(4'd2,  8'h10, 8'h20, 8'hF0, 4'b1001, 1'b1, 2, 0);  // leave carry_q=1

      // Abort an operation in flight with reset.
      @(negedge clk);
      op = ABORT_OP; a = 8'hFF; b = 8'hFF; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (ABORT_WAIT) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_done", {31'd0, done}, 32'd0);
      chk("abort_flags_cs", {31'd0, flags_cs}, 32'd0);
      chk("abort_flags_out", {28'd0, flags_out}, 32'd0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      repeat (12) @(negedge clk);
      chk("post_abort_busy", {31'd0, busy}, 32'd0);
      run_op(4'd1,  8'h00, 8'h00, 8'h00, 4'b0100, 1'b1, 2, 0);  // carry_q cleared
      repeat (4) @(negedge clk);
      chk("queue_drained", sb.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

endmodule
